// File: rtl/irq_timer_bank.sv
// Programmable down-counter timers plus external edge interrupts, latched as pending bits and masked
// into a prioritised request for the CPU. The request outputs are combinational from the pending and mask state.
module irq_timer_bank #(
   parameter int N_TIMERS = 2,
   parameter int N_EXT    = 2,
   parameter int CNT_W    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_EXT-1:0]            ext_int,
   input  logic                        wr_en,
   input  logic [3:0]                  wr_addr,
   input  logic [CNT_W-1:0]            wr_data,
   output logic [N_EXT+N_TIMERS-1:0]   int_vector,
   output logic                        irq,
   output logic [3:0]                  irq_id,
   output logic [N_TIMERS-1:0]         timer_pulse
);
   localparam int NSRC = N_EXT + N_TIMERS;

   logic [N_TIMERS-1:0][CNT_W-1:0] reload_q, reload_d;
   logic [N_TIMERS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [N_TIMERS-1:0]            en_q, en_d;
   logic [N_TIMERS-1:0]            per_q, per_d;
   logic [N_TIMERS-1:0]            pulse_q, pulse_d;
   logic [NSRC-1:0]                mask_q, mask_d;
   logic [NSRC-1:0]                pend_q, pend_d;
   logic [NSRC-1:0]                set_vec, ack_vec, wdat_src;
   logic [N_EXT-1:0]               sync1_q, sync2_q, sync3_q;

   if (NSRC <= CNT_W) begin : g_wd
      assign wdat_src = wr_data[NSRC-1:0];
   end else begin : g_wd
      assign wdat_src = {{(NSRC-CNT_W){1'b0}}, wr_data};
   end

   always_comb begin
      reload_d = reload_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      per_d    = per_q;
      mask_d   = mask_q;
      pulse_d  = '0;
      set_vec  = '0;
      ack_vec  = '0;
      if (wr_en && wr_addr == 4'd8) mask_d = wdat_src;
      if (wr_en && wr_addr == 4'd9) ack_vec = wdat_src;
      set_vec[N_EXT-1:0] = sync2_q & ~sync3_q;
      for (int i = 0; i < N_TIMERS; i++) begin
         if (wr_en && wr_addr == 4'(2*i)) reload_d[i] = wr_data;
         // A CTRL write in the expiry cycle takes priority and suppresses that expiry.
         if (wr_en && wr_addr == 4'(2*i+1)) begin
            en_d[i]  = wr_data[0];
            per_d[i] = wr_data[1];
            if (wr_data[0]) cnt_d[i] = reload_q[i];
         end else if (en_q[i]) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
               pulse_d[i]        = 1'b1;
               set_vec[N_EXT+i]  = 1'b1;
               if (per_q[i]) cnt_d[i] = reload_q[i];
               else          en_d[i]  = 1'b0;
            end
         end
      end
      pend_d = (pend_q & ~ack_vec) | set_vec;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reload_q <= '0;
         cnt_q    <= '0;
         en_q     <= '0;
         per_q    <= '0;
         pulse_q  <= '0;
         mask_q   <= '0;
         pend_q   <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         sync3_q  <= '0;
      end else begin
         reload_q <= reload_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         per_q    <= per_d;
         pulse_q  <= pulse_d;
         mask_q   <= mask_d;
         pend_q   <= pend_d;
         sync1_q  <= ext_int;
         sync2_q  <= sync1_q;
         sync3_q  <= sync2_q;
      end
   end

   assign int_vector  = pend_q & mask_q;
   assign irq         = |int_vector;
   assign timer_pulse = pulse_q;

   always_comb begin
      irq_id = '0;
      for (int k = NSRC-1; k >= 0; k--) begin
         if (int_vector[k]) irq_id = 4'(k);
      end
   end
endmodule

// File: doc/irq_timer_bank.md
# irq_timer_bank

Parametrised interrupt and timer subsystem that replaces the single fixed timer and raw interrupt wiring around the CPU. It holds N_TIMERS programmable down-counters (one-shot or periodic) and N_EXT external interrupt lines. It latches every event as a pending bit and applies a mask. It presents the CPU with a masked interrupt vector, a single request line and the index of the highest-priority source. The CPU programs it through a simple write port driven from its output-device registers.

## Interface
- N_TIMERS, default 2: number of timer channels, 1..4.
- N_EXT, default 2: number of external interrupt lines, 1..8.
- CNT_W, default 8: counter and reload width, 4..16.
- NSRC, derived: N_EXT + N_TIMERS, maximum 12.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- ext_int  in  N_EXT  external interrupt requests, asynchronous, rising-edge sensitive.
- wr_en  in  1  register write strobe, one write per cycle.
- wr_addr  in  4  register address.
- wr_data  in  CNT_W  write data.
- int_vector  out  NSRC  pending & mask. Bits [N_EXT-1:0] are external, bits above are timers.
- irq  out  1  OR of int_vector.
- irq_id  out  4  index of lowest-numbered set bit of int_vector; 0 when irq=0.
- timer_pulse  out  N_TIMERS  one-cycle registered pulse per expiry.

## Operation
- Register map:
  - Address 2i: RELOAD[i].
  - Address 2i+1: CTRL[i], where bit0 = EN and bit1 = PERIODIC; other bits ignored.
  - Address 8: MASK[NSRC-1:0], where 1 = enabled.
  - Address 9: ACK, write-1-to-clear pending bits.
  - Unmapped addresses and bits above NSRC are ignored.
- Reset state: all counters, RELOAD, CTRL, MASK, pending, synchronisers = 0. All outputs 0.
- Timer channel states: IDLE (EN=0) and RUN (EN=1).
  - Writing CTRL with EN=1 loads count := RELOAD and enters RUN. This applies even if already running (restart).
  - Writing EN=0 enters IDLE; count holds its value.
  - In RUN, count ≠ 0: decrement.
  - In RUN, count = 0: expiry.
- Expiry:
  - Set pending[N_EXT+i] and pulse timer_pulse[i].
  - PERIODIC=1: count := RELOAD, stay in RUN.
  - PERIODIC=0: EN clears to 0, go to IDLE.
- Period = RELOAD+1 cycles. RELOAD=0 with PERIODIC=1 expires every cycle.
- Writing RELOAD while running does not disturb count; the new value applies at the next reload or restart.
- External lines:
  - Two-flop synchroniser, then rising-edge detector, then set pending[j].
  - Level held high sets pending only once.
- Pending bits set regardless of MASK. Masking affects only int_vector, irq and irq_id.
- Unmasking a pending bit asserts irq in the next cycle.
- Priority: fixed; lowest index wins (external before timers).
- Simultaneous events:
  - Set and ACK of the same bit in the same cycle: set wins, bit stays 1.
  - CTRL restart write in the same cycle as expiry: write wins, no pending set.
  - Several sources in one cycle: all latched.
- Reset asserted mid-count: immediate clear, no pulse, no pending. After release, channels stay IDLE until reprogrammed.

## Timing
- Register writes take effect at the rising edge where wr_en=1.
- Timer:
  - EN write at edge 0: count=RELOAD=R after edge 0, count reaches 0 after edge R.
  - At edge R+1: pending and timer_pulse set. Both are visible in the cycle after edge R+1.
  - timer_pulse is high exactly one cycle per expiry.
- External: ext_int rising and stable before edge k: pending visible after edge k+2, i.e. 3-cycle latency.
- int_vector, irq and irq_id are combinational from pending and MASK registers; no added latency.
- ACK write at edge t: bit is 0 after edge t unless re-set in the same cycle.

## Test plan
- Reset: hold reset=0 with ext_int toggling and writes active. Required: all outputs 0. Release: outputs stay 0.
- Periodic timer 0:
  - Stimulus: RELOAD[0]=3, MASK=all 1s, CTRL[0]=3 at edge 0.
  - Required: timer_pulse[0] after edges 4, 8, 12. int_vector[2]=1 after edge 4. irq_id=2.
  - ACK bit 2: cleared, then re-set at edge 8.
- One-shot:
  - Stimulus: RELOAD[1]=0, CTRL[1]=1.
  - Required: single pulse one cycle after the write, CTRL[1].EN reads 0 afterwards, no further pulses over 20 cycles.
- External edge and mask:
  - Stimulus: MASK=0, raise ext_int[1] and hold high.
  - Required: pending set after 3 edges, irq=0. MASK=2'b10 gives irq=1, irq_id=1.
  - ACK: irq=0, no re-trigger while the line stays high.
- Priority and collision:
  - Stimulus: ext_int[0] and timer 1 pending together. Required: irq_id=0; after ACK bit 0, irq_id=3.
  - Stimulus: ACK timer bit in the same cycle as its expiry. Required: bit remains 1.
- Restart and reset mid-operation:
  - Stimulus: CTRL re-write at count=1 with RELOAD=5. Required: next pulse 6 cycles later.
  - Stimulus: reset pulse mid-count. Required: immediate clear, no pulse after release.
